// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber NTT datapath: polynomial geometry,
// butterfly_core mode encodings and the ntt_ctrl sequencer state type.
package kyber_pkg;

  localparam int KYBER_N      = 256;
  localparam int LOG_N        = 8;
  localparam int NTT_LAYERS   = 7;
  localparam int BF_PER_LAYER = 128;

  localparam logic [1:0] BF_MODE_NTT    = 2'd0;
  localparam logic [1:0] BF_MODE_INTT   = 2'd1;
  localparam logic [1:0] BF_MODE_MULT   = 2'd2;
  localparam logic [1:0] BF_MODE_ADDSUB = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address / twiddle index generator.
// Ports:
//   layer    in  3  current layer 0..6
//   b        in  7  butterfly index within the layer 0..127
//   inv      in  1  0 = NTT (len halves per layer), 1 = INTT (len doubles)
//   rd_addr0 out 8  first operand address
//   rd_addr1 out 8  second operand address (rd_addr0 + len)
//   tw_idx   out 7  twiddle ROM index
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic [2:0] layer,
  input  logic [6:0] b,
  input  logic       inv,
  output logic [7:0] rd_addr0,
  output logic [7:0] rd_addr1,
  output logic [6:0] tw_idx
);

  logic [2:0] sh;       // log2(len)
  logic [7:0] len;
  logic [7:0] grp;
  logic [7:0] off;
  logic [7:0] tw_full;

  always_comb begin
    sh  = inv ? (layer + 3'd1) : (3'd7 - layer);
    len = 8'd1 << sh;
    grp = {1'b0, b} >> sh;
    off = {1'b0, b} & (len - 8'd1);
    // grp * 2 * len + off; the two fields never overlap so OR is an add
    rd_addr0 = ((grp << sh) << 1) | off;
    rd_addr1 = rd_addr0 + len;
    tw_full  = inv ? ((8'd128 >> layer) - 8'd1 - grp)
                   : ((8'd1 << layer) + grp);
    tw_idx   = tw_full[6:0];
  end

endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer for a single butterfly_core running a full 256-point Kyber
// NTT/INTT (7 layers x 128 butterflies), with a write-back delay line.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, inv          transform request and direction (sampled when idle)
//   busy, done          status to the poly op scheduler
//   bf_mode             butterfly_core mode (0 when idle)
//   rd_en, rd_addr0/1   coefficient RAM read pair
//   tw_idx              twiddle ROM index
//   wr_en, wr_addr0/1   write-back pair, rd_* delayed by RD_LAT + BF_LAT
module ntt_ctrl
  import kyber_pkg::*;
#(
  parameter int BF_LAT = 5,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic [1:0] bf_mode,
  output logic       rd_en,
  output logic [7:0] rd_addr0,
  output logic [7:0] rd_addr1,
  output logic [6:0] tw_idx,
  output logic       wr_en,
  output logic [7:0] wr_addr0,
  output logic [7:0] wr_addr1
);

  localparam int WB_LAT = RD_LAT + BF_LAT;
  localparam int CNT_W  = $clog2(WB_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ntt_state_e       state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [6:0]       b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_q, inv_d;

  logic [WB_LAT-1:0] dl_en_q, dl_en_d;
  logic [7:0]        dl_a0_q [WB_LAT];
  logic [7:0]        dl_a0_d [WB_LAT];
  logic [7:0]        dl_a1_q [WB_LAT];
  logic [7:0]        dl_a1_d [WB_LAT];

  logic [7:0] ag_addr0;
  logic [7:0] ag_addr1;
  logic [6:0] ag_tw;

  ntt_addr_gen u_addr_gen (
    .layer    (layer_q),
    .b        (b_q),
    .inv      (inv_q),
    .rd_addr0 (ag_addr0),
    .rd_addr1 (ag_addr1),
    .tw_idx   (ag_tw)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      // DONE is not busy, so a new start is accepted in the done cycle
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d = ST_ISSUE;
          inv_d   = inv;
          layer_d = 3'd0;
          b_d     = 7'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        b_d   = b_q + 7'd1;
        if (b_q == 7'd127) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_ONE;
        end
      end
      // Hold off reads until the last write of this layer has committed
      ST_DRAIN: begin
        busy = 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (layer_q == 3'd6) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            layer_d = layer_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bf_mode  = busy ? (inv_q ? BF_MODE_INTT : BF_MODE_NTT) : BF_MODE_NTT;
    rd_addr0 = rd_en ? ag_addr0 : 8'd0;
    rd_addr1 = rd_en ? ag_addr1 : 8'd0;
    tw_idx   = rd_en ? ag_tw : 7'd0;

    dl_en_d    = {dl_en_q[WB_LAT-2:0], rd_en};
    dl_a0_d[0] = rd_addr0;
    dl_a1_d[0] = rd_addr1;
    for (int i = 1; i < WB_LAT; i++) begin
      dl_a0_d[i] = dl_a0_q[i-1];
      dl_a1_d[i] = dl_a1_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      layer_q <= 3'd0;
      b_q     <= 7'd0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      dl_en_q <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        dl_a0_q[i] <= 8'd0;
        dl_a1_q[i] <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      dl_en_q <= dl_en_d;
      for (int i = 0; i < WB_LAT; i++) begin
        dl_a0_q[i] <= dl_a0_d[i];
        dl_a1_q[i] <= dl_a1_d[i];
      end
    end
  end

  assign wr_en    = dl_en_q[WB_LAT-1];
  assign wr_addr0 = dl_a0_q[WB_LAT-1];
  assign wr_addr1 = dl_a1_q[WB_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: loop-form Kyber NTT/INTT reference,
// modelled coefficient RAM and butterfly, control and reset scenarios.
module tb_ntt_ctrl;

  localparam int Q = 3329;

  logic       clk = 1'b0;
  logic       rst, start, inv;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] bf_mode;
  logic [7:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [6:0] tw_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ntt_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inv      (inv),
    .busy     (busy),
    .done     (done),
    .bf_mode  (bf_mode),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_idx   (tw_idx),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1)
  );

  typedef struct {int a0; int a1; int tw;} rd_t;
  typedef struct {int c; int a0; int a1; int v0; int v1;} wb_t;

  int  mem   [256];
  int  gold  [256];
  int  zetas [128];
  rd_t exp_rd[$];
  wb_t pend  [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void bfly(input bit iv, input int a, input int b, input int z,
                               output int o1, output int o2);
    int t;
    if (!iv) begin
      t  = (z * b) % Q;
      o1 = (a + t) % Q;
      o2 = (a - t + Q) % Q;
    end else begin
      o1 = (a + b) % Q;
      o2 = (((b - a + Q) % Q) * z) % Q;
    end
  endfunction

  // Textbook Kyber loops: produce the expected issue order and the golden result
  task automatic build_ref(input bit iv);
    int k, len, o1, o2;
    exp_rd.delete();
    gold = mem;
    k   = iv ? 127 : 1;
    len = iv ? 2 : 128;
    for (int l = 0; l < 7; l++) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          exp_rd.push_back('{j, j + len, k});
          bfly(iv, gold[j], gold[j+len], zetas[k], o1, o2);
          gold[j]     = o1;
          gold[j+len] = o2;
        end
        k = iv ? k - 1 : k + 1;
      end
      len = iv ? len * 2 : len / 2;
    end
  endtask

  function automatic logic [63:0] pack_rd(input int a0, input int a1, input int tw);
    return 64'(a0 * 65536 + a1 * 256 + tw);
  endfunction

  task automatic run_xform(input bit iv, input bit started, input bit chain,
                           input bit next_iv, input bit poke_busy);
    int  done_c, last_wr, busy_n, hazards, lat_bad, mode_bad, extra, bad_coef, o1, o2;
    bit  inflight [256];
    rd_t e;
    wb_t w;
    string nm;
    nm = iv ? "intt" : "ntt";
    for (int i = 0; i < 256; i++) begin
      mem[i]      = int'($urandom_range(Q - 1));
      inflight[i] = 1'b0;
    end
    build_ref(iv);
    pend.delete();
    if (!started) begin
      start = 1'b1;
      inv   = iv;
      @(posedge clk); #1;
    end
    start = 1'b0;
    inv   = ~iv;
    done_c = -1; last_wr = -1; busy_n = 0; hazards = 0; lat_bad = 0;
    mode_bad = 0; extra = 0; bad_coef = 0;
    for (int c = 1; c <= 1200; c++) begin
      if (busy) busy_n++;
      if (busy && bf_mode !== {1'b0, iv}) mode_bad++;
      if (c == 1) begin
        check({nm, "_first_rd_en"}, 64'(rd_en), 64'd1);
        check({nm, "_first_pair"}, pack_rd(rd_addr0, rd_addr1, tw_idx),
              iv ? pack_rd(0, 2, 127) : pack_rd(0, 128, 1));
      end
      if (c == 932 && !iv)
        check("ntt_l6_last", pack_rd(rd_addr0, rd_addr1, tw_idx), pack_rd(253, 255, 127));
      if (c == 805 && iv)
        check("intt_l6_first", pack_rd(rd_addr0, rd_addr1, tw_idx), pack_rd(0, 128, 1));
      if (rd_en) begin
        if (exp_rd.size() == 0) extra++;
        else begin
          e = exp_rd.pop_front();
          check({nm, "_rd_pair"}, pack_rd(rd_addr0, rd_addr1, tw_idx), pack_rd(e.a0, e.a1, e.tw));
        end
        if (inflight[rd_addr0] || inflight[rd_addr1]) hazards++;
        inflight[rd_addr0] = 1'b1;
        inflight[rd_addr1] = 1'b1;
        bfly(iv, mem[rd_addr0], mem[rd_addr1], zetas[tw_idx], o1, o2);
        pend.push_back('{c, int'(rd_addr0), int'(rd_addr1), o1, o2});
      end
      if (wr_en) begin
        if (pend.size() == 0) extra++;
        else begin
          w = pend.pop_front();
          check({nm, "_wr_pair"}, pack_rd(wr_addr0, wr_addr1, 0), pack_rd(w.a0, w.a1, 0));
          if (c - w.c != 6) lat_bad++;
          mem[w.a0] = w.v0;
          mem[w.a1] = w.v1;
          inflight[w.a0] = 1'b0;
          inflight[w.a1] = 1'b0;
          last_wr = c;
        end
      end
      if (done) begin
        done_c = c;
        check({nm, "_done_mode"}, 64'({busy, bf_mode}), 64'd0);
        if (chain) begin
          start = 1'b1;
          inv   = next_iv;
        end
        break;
      end
      start = (poke_busy && c == 400);
      @(posedge clk); #1;
    end
    check({nm, "_done_cycle"}, 64'(done_c), 64'd939);
    check({nm, "_last_wr"}, 64'(last_wr), 64'd938);
    check({nm, "_busy_cycles"}, 64'(busy_n), 64'd938);
    check({nm, "_hazards"}, 64'(hazards), 64'd0);
    check({nm, "_wb_latency"}, 64'(lat_bad), 64'd0);
    check({nm, "_bf_mode"}, 64'(mode_bad), 64'd0);
    check({nm, "_extra_strobes"}, 64'(extra), 64'd0);
    check({nm, "_missing_issues"}, 64'(exp_rd.size()), 64'd0);
    check({nm, "_missing_writes"}, 64'(pend.size()), 64'd0);
    for (int i = 0; i < 256; i++) if (mem[i] != gold[i]) bad_coef++;
    check({nm, "_coeffs"}, 64'(bad_coef), 64'd0);
    if (chain) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    for (int i = 0; i < 128; i++) zetas[i] = int'($urandom_range(Q - 1));
    rst   = 1'b1;
    start = 1'b1;
    inv   = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ctrl", 64'({busy, done, bf_mode, rd_en, wr_en}), 64'd0);
      check("rst_addr", 64'({rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1}), 64'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({busy, rd_en, done}), 64'd0);

    // NTT with a start poke at cycle 400, restarted as INTT in its done cycle
    run_xform(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_xform(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_xform(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a transform
    start = 1'b1;
    inv   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctrl", 64'({busy, done, bf_mode, rd_en, wr_en}), 64'd0);
    check("midrst_addr", 64'({rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1}), 64'd0);
    rst   = 1'b0;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wr_en || rd_en || busy || done) stray++;
    end
    check("midrst_no_activity", 64'(stray), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
